// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer in front of a single 64-bit data memory.
// One transaction at a time: IDLE samples requests, ACCESS drives the memory
// strobes for one cycle, DONE returns a one-cycle ack with err/rdata.
module data_memory_arbiter #(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [63:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [63:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [63:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [63:0]       p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [63:0]       mem_read_data,
  output logic              busy,
  output logic              grant_id
);

  // One extra bit so NUM_WORDS itself is representable in the comparison.
  localparam logic [ADDR_W:0] LIMIT = NUM_WORDS[ADDR_W:0];

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_reg;
  logic              lat_we_reg;
  logic              lat_err_reg;

  logic              p0_win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [63:0]       sel_wdata;
  logic              sel_ok;

  // Pick the winner: a lone requester wins, a tie goes to the port not last served.
  always_comb begin
    p0_win    = p0_req && (!p1_req || grant_id);
    sel_we    = p0_win ? p0_we    : p1_we;
    sel_addr  = p0_win ? p0_addr  : p1_addr;
    sel_wdata = p0_win ? p0_wdata : p1_wdata;
    sel_ok    = ({1'b0, sel_addr} < LIMIT);
  end

  assign busy = (state_reg != IDLE);

  // Sequencer: latch request, pulse memory strobes, then return ack/err/rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      lat_we_reg     <= 1'b0;
      lat_err_reg    <= 1'b0;
      grant_id       <= 1'b1;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      p0_ack         <= 1'b0;
      p0_err         <= 1'b0;
      p0_rdata       <= '0;
      p1_ack         <= 1'b0;
      p1_err         <= 1'b0;
      p1_rdata       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant_id       <= ~p0_win;
            lat_we_reg     <= sel_we;
            lat_err_reg    <= ~sel_ok;
            mem_address    <= sel_addr;
            mem_write_data <= sel_wdata;
            mem_write      <= sel_we & sel_ok;
            mem_read       <= ~sel_we & sel_ok;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (grant_id == 1'b0) begin
            p0_ack   <= 1'b1;
            p0_err   <= lat_err_reg;
            p0_rdata <= (!lat_we_reg && !lat_err_reg) ? mem_read_data : 64'd0;
          end else begin
            p1_ack   <= 1'b1;
            p1_err   <= lat_err_reg;
            p1_rdata <= (!lat_we_reg && !lat_err_reg) ? mem_read_data : 64'd0;
          end
          state_reg <= DONE;
        end
        DONE: begin
          p0_ack    <= 1'b0;
          p0_err    <= 1'b0;
          p1_ack    <= 1'b0;
          p1_err    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios followed by
// random single-port transactions, checked against a word-level memory model.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [5:0]  p0_addr = '0;
  logic [63:0] p0_wdata = '0;
  logic        p0_ack, p0_err;
  logic [63:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [5:0]  p1_addr = '0;
  logic [63:0] p1_wdata = '0;
  logic        p1_ack, p1_err;
  logic [63:0] p1_rdata;
  logic [5:0]  mem_address;
  logic [63:0] mem_write_data;
  logic        mem_read, mem_write;
  logic [63:0] mem_read_data;
  logic        busy, grant_id;

  int n_vec = 0;
  int n_err = 0;

  // Environment memory (64 physical words) and the reference model of the 8 valid words.
  logic [63:0] mem [0:63];
  logic [63:0] exp_mem [0:7];
  logic [63:0] exp_rd [0:1];
  logic        init_mem = 1'b1;

  data_memory_arbiter #(.NUM_WORDS(8), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    if (i == 0) return 64'd1000;
    if (i == 5) return 64'd3;
    return 64'h1111_0000 + 64'(i);
  endfunction

  // Memory: asynchronous read, write committed on the rising edge.
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_address] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [5:0] a, input logic [63:0] d);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_p0_ack", 64'(p0_ack), 64'd0);
    chk("rst_p1_ack", 64'(p1_ack), 64'd0);
    chk("rst_p0_rdata", p0_rdata, 64'd0);
    chk("rst_p1_rdata", p1_rdata, 64'd0);
    chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd1);
  endtask

  // One single-port transaction, started from a negedge while the DUT is idle.
  task automatic do_txn(input int port, input logic we, input logic [5:0] addr,
                        input logic [63:0] wdata);
    logic        exp_err;
    logic [63:0] exp_data;
    logic        ack, other_ack, err;
    logic [63:0] rdata, other_rdata;
    int cyc = 0, rd_cnt = 0, wr_cnt = 0;
    bit got = 0;
    exp_err  = (addr >= 6'd8);
    exp_data = (we || exp_err) ? 64'd0 : exp_mem[addr[2:0]];
    drive(port, 1'b1, we, addr, wdata);
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (cyc == 1) begin
        chk("access_addr", 64'(mem_address), 64'(addr));
        if (!exp_err) chk("access_wdata", mem_write_data, wdata);
        chk("access_busy", 64'(busy), 64'd1);
        chk("access_grant", 64'(grant_id), 64'(port));
        // Inputs changed after the sample must not affect this transaction.
        drive(port, 1'b1, ~we, 6'($urandom_range(0, 63)), {$urandom, $urandom});
      end
      got = (port == 0) ? p0_ack : p1_ack;
    end
    ack         = (port == 0) ? p0_ack   : p1_ack;
    err         = (port == 0) ? p0_err   : p1_err;
    rdata       = (port == 0) ? p0_rdata : p1_rdata;
    other_ack   = (port == 0) ? p1_ack   : p0_ack;
    other_rdata = (port == 0) ? p1_rdata : p0_rdata;
    chk("ack_latency", 64'(cyc), 64'd2);
    chk("ack_seen", 64'(ack), 64'd1);
    chk("err", 64'(err), 64'(exp_err));
    chk("rdata", rdata, exp_data);
    chk("other_ack", 64'(other_ack), 64'd0);
    chk("other_rdata_hold", other_rdata, exp_rd[1 - port]);
    chk("read_strobes", 64'(rd_cnt), 64'((!we && !exp_err) ? 1 : 0));
    chk("write_strobes", 64'(wr_cnt), 64'((we && !exp_err) ? 1 : 0));
    exp_rd[port] = exp_data;
    if (we && !exp_err) exp_mem[addr[2:0]] = wdata;
    drive(port, 1'b0, 1'b0, 6'd0, 64'd0);
    @(negedge clk);
    chk("ack_pulse_end", 64'((port == 0) ? p0_ack : p1_ack), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    $display("txn port=%0d we=%0d addr=%0d wdata=%h err=%0d rdata=%h", port, we, addr, wdata,
             err, rdata);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_rd[0] = 64'd0;
    exp_rd[1] = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int acks, port_exp, a0, a1;
    for (int i = 0; i < 8; i++) exp_mem[i] = init_word(i);
    exp_rd[0] = 64'd0;
    exp_rd[1] = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_mem_wdata", mem_write_data, 64'd0);
    init_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic read, write then read-back, error write.
    do_txn(0, 1'b0, 6'd0, 64'd0);
    do_txn(1, 1'b1, 6'd6, 64'hDEADBEEF_01234567);
    do_txn(0, 1'b0, 6'd6, 64'd0);
    do_txn(0, 1'b1, 6'd8, 64'd5);
    do_txn(0, 1'b0, 6'd0, 64'd0);
    do_txn(1, 1'b0, 6'd63, 64'd0);

    // Both ports requesting continuously from reset: grants alternate 0,1,0,1.
    apply_reset();
    a0 = 1; a1 = 2;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'(a0);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 6'(a1);
    acks = 0;
    port_exp = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 12) begin
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
      if (p0_ack || p1_ack) begin
        chk("rr_single_ack", 64'({p0_ack, p1_ack} == 2'b11), 64'd0);
        chk("rr_port", 64'(p1_ack), 64'(port_exp));
        chk("rr_spacing", 64'(c), 64'(2 + 3 * acks));
        chk("rr_rdata", p1_ack ? p1_rdata : p0_rdata, exp_mem[port_exp == 0 ? a0 : a1]);
        $display("rr cycle=%0d p0_ack=%0d p1_ack=%0d", c, p0_ack, p1_ack);
        acks++;
        port_exp = 1 - port_exp;
      end
    end
    chk("rr_ack_count", 64'(acks), 64'd4);
    @(negedge clk);
    @(negedge clk);

    // Reset during ACCESS of a port 1 write: strobe drops at once, no ack.
    drive(1, 1'b1, 1'b1, 6'd3, 64'h0BAD_F00D_0BAD_F00D);
    @(negedge clk);
    chk("midrst_wr_strobe", 64'(mem_write), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_strobe_drop", 64'({mem_read, mem_write}), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    drive(1, 1'b0, 1'b0, 6'd0, 64'd0);
    exp_rd[0] = 64'd0;
    exp_rd[1] = 64'd0;
    @(negedge clk);
    chk("midrst_no_ack", 64'(p1_ack), 64'd0);
    chk("midrst_grant", 64'(grant_id), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    $display("mid-access reset applied");
    do_txn(0, 1'b0, 6'd5, 64'd0);

    // Random single-port traffic, including out-of-range addresses.
    for (int t = 0; t < 40; t++) begin
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             6'($urandom_range(0, 11)), {$urandom, $urandom});
    end

    // Final memory image must match the model.
    for (int i = 0; i < 8; i++) chk("final_mem", mem[i], exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
